// File: rtl/axi_timer_pkg.sv
// Shared constants, FSM state types and helpers for the AXI4-Lite timer peripheral.
package axi_timer_pkg;

  localparam int unsigned TIMER_W    = 32;
  localparam int unsigned REG_ADDR_W = 4;

  localparam logic [REG_ADDR_W-1:0] ADDR_CONTROL   = 4'h0;
  localparam logic [REG_ADDR_W-1:0] ADDR_PRESCALER = 4'h4;
  localparam logic [REG_ADDR_W-1:0] ADDR_COUNTER   = 4'h8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int unsigned CTRL_EN_BIT  = 0;
  localparam int unsigned CTRL_CLR_BIT = 1;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_AW,
    WR_W,
    WR_B
  } wr_state_e;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_AR,
    RD_R
  } rd_state_e;

  function automatic logic addr_mapped(input logic [REG_ADDR_W-1:0] addr);
    return (addr == ADDR_CONTROL) || (addr == ADDR_PRESCALER) || (addr == ADDR_COUNTER);
  endfunction

  function automatic logic [TIMER_W-1:0] apply_strb(input logic [TIMER_W-1:0] old_val,
                                                    input logic [TIMER_W-1:0] new_val,
                                                    input logic [TIMER_W/8-1:0] strb);
    logic [TIMER_W-1:0] merged;
    merged = old_val;
    for (int i = 0; i < TIMER_W / 8; i++) begin
      if (strb[i]) merged[8*i +: 8] = new_val[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/axi_timer_core.sv
// Prescaled up-counter: COUNTER advances once every prescaler+1 enabled cycles.
module timer_core
  import axi_timer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               clear,
  input  logic [TIMER_W-1:0] prescaler,
  output logic [TIMER_W-1:0] count
);

  logic [TIMER_W-1:0] presc_cnt_q, presc_cnt_d;
  logic [TIMER_W-1:0] count_q, count_d;

  // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
  always_comb begin
    presc_cnt_d = presc_cnt_q;
    count_d     = count_q;
    if (clear) begin
      presc_cnt_d = '0;
      count_d     = '0;
    end else if (enable) begin
      // Equality compare: a prescaler lowered below the running count waits for wrap.
      if (presc_cnt_q == prescaler) begin
        presc_cnt_d = '0;
        count_d     = count_q + 1'b1;
      end else begin
        presc_cnt_d = presc_cnt_q + 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_cnt_q <= '0;
      count_q     <= '0;
    end else begin
      presc_cnt_q <= presc_cnt_d;
      count_q     <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/axi_timer.sv
// AXI4-Lite slave exposing CONTROL, PRESCALER and COUNTER of a prescaled timer.
module axi_timer
  import axi_timer_pkg::*;
#(
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ADDR_WIDTH = 32
) (
  input  logic                        axi_clk,
  input  logic                        rst,
  input  logic [AXI_ADDR_WIDTH-1:0]   AWADDR,
  input  logic                        AWVALID,
  output logic                        AWREADY,
  input  logic [AXI_DATA_WIDTH-1:0]   WDDATA,
  input  logic [AXI_DATA_WIDTH/8-1:0] WDSTRB,
  input  logic                        WDVALID,
  output logic                        WDREADY,
  output logic [1:0]                  BRESP,
  output logic                        BVALID,
  input  logic                        BREADY,
  input  logic [AXI_ADDR_WIDTH-1:0]   ARADDR,
  input  logic                        ARVALID,
  output logic                        ARREADY,
  output logic [AXI_DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]                  RRESP,
  output logic                        RVALID,
  input  logic                        RREADY
);

  wr_state_e             wr_state_q, wr_state_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [REG_ADDR_W-1:0] waddr_q, waddr_d;
  logic                  wr_fire;

  rd_state_e             rd_state_q, rd_state_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [TIMER_W-1:0]    rdata_q, rdata_d;

  logic                  ctrl_en_q, ctrl_en_d;
  logic [TIMER_W-1:0]    prescaler_q, prescaler_d;
  logic                  clr_pulse;
  logic [TIMER_W-1:0]    count;
  logic [TIMER_W-1:0]    rd_mux;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{AWADDR[AXI_ADDR_WIDTH-1:REG_ADDR_W], ARADDR[AXI_ADDR_WIDTH-1:REG_ADDR_W]};

  always_comb begin
    wr_state_d = wr_state_q;
    awready_d  = awready_q;
    wready_d   = wready_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    waddr_d    = waddr_q;
    wr_fire    = 1'b0;
    unique case (wr_state_q)
      WR_IDLE: begin
        if (AWVALID && WDVALID) begin
          awready_d  = 1'b1;
          wr_state_d = WR_AW;
        end
      end
      WR_AW: begin
        awready_d = 1'b0;
        if (AWVALID) begin
          waddr_d    = AWADDR[REG_ADDR_W-1:0];
          wready_d   = 1'b1;
          wr_state_d = WR_W;
        end else begin
          wr_state_d = WR_IDLE;
        end
      end
      WR_W: begin
        if (WDVALID) begin
          wr_fire    = 1'b1;
          wready_d   = 1'b0;
          bvalid_d   = 1'b1;
          bresp_d    = addr_mapped(waddr_q) ? RESP_OKAY : RESP_SLVERR;
          wr_state_d = WR_B;
        end
      end
      WR_B: begin
        if (BREADY) begin
          bvalid_d   = 1'b0;
          wr_state_d = WR_IDLE;
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  // CLEAR is a strobe into the core; it never lands in a register, so it always reads 0.
  always_comb begin
    ctrl_en_d   = ctrl_en_q;
    prescaler_d = prescaler_q;
    clr_pulse   = 1'b0;
    if (wr_fire) begin
      case (waddr_q)
        ADDR_CONTROL: begin
          if (WDSTRB[0]) begin
            ctrl_en_d = WDDATA[CTRL_EN_BIT];
            clr_pulse = WDDATA[CTRL_CLR_BIT];
          end
        end
        ADDR_PRESCALER: prescaler_d = apply_strb(prescaler_q, WDDATA, WDSTRB);
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    case (ARADDR[REG_ADDR_W-1:0])
      ADDR_CONTROL:   rd_mux[CTRL_EN_BIT] = ctrl_en_q;
      ADDR_PRESCALER: rd_mux = prescaler_q;
      ADDR_COUNTER:   rd_mux = count;
      default:        rd_mux = '0;
    endcase
  end

  // Read samples pre-write register values, so a same-cycle write is not visible yet.
  always_comb begin
    rd_state_d = rd_state_q;
    arready_d  = arready_q;
    rvalid_d   = rvalid_q;
    rresp_d    = rresp_q;
    rdata_d    = rdata_q;
    unique case (rd_state_q)
      RD_IDLE: begin
        if (ARVALID && !rvalid_q) begin
          arready_d  = 1'b1;
          rd_state_d = RD_AR;
        end
      end
      RD_AR: begin
        if (ARVALID) begin
          arready_d  = 1'b0;
          rvalid_d   = 1'b1;
          rdata_d    = rd_mux;
          rresp_d    = addr_mapped(ARADDR[REG_ADDR_W-1:0]) ? RESP_OKAY : RESP_SLVERR;
          rd_state_d = RD_R;
        end
      end
      RD_R: begin
        if (RREADY) begin
          rvalid_d   = 1'b0;
          rd_state_d = RD_IDLE;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge axi_clk or posedge rst) begin
    if (rst) begin
      wr_state_q  <= WR_IDLE;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bresp_q     <= RESP_OKAY;
      waddr_q     <= '0;
      rd_state_q  <= RD_IDLE;
      arready_q   <= 1'b0;
      rvalid_q    <= 1'b0;
      rresp_q     <= RESP_OKAY;
      rdata_q     <= '0;
      ctrl_en_q   <= 1'b0;
      prescaler_q <= '0;
    end else begin
      wr_state_q  <= wr_state_d;
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
      waddr_q     <= waddr_d;
      rd_state_q  <= rd_state_d;
      arready_q   <= arready_d;
      rvalid_q    <= rvalid_d;
      rresp_q     <= rresp_d;
      rdata_q     <= rdata_d;
      ctrl_en_q   <= ctrl_en_d;
      prescaler_q <= prescaler_d;
    end
  end

  timer_core u_core (
    .clk       (axi_clk),
    .rst       (rst),
    .enable    (ctrl_en_q),
    .clear     (clr_pulse),
    .prescaler (prescaler_q),
    .count     (count)
  );

  assign AWREADY = awready_q;
  assign WDREADY = wready_q;
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;
  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RRESP   = rresp_q;
  assign RDATA   = rdata_q;

endmodule

// File: tb/tb_axi_timer.sv
// Directed bench for axi_timer: register access, protocol timing, timer counting and errors.
module tb_axi_timer;

  logic        axi_clk = 1'b0;
  logic        rst;
  logic [31:0] AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDDATA;
  logic [3:0]  WDSTRB;
  logic        WDVALID;
  logic        WDREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [31:0] ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;

  int total = 0;
  int bad   = 0;

  logic obs_aw_pulse, obs_wready, obs_wready_drop, obs_b_held, obs_b_drop;
  logic obs_ar_drop, obs_r_held, obs_r_drop;

  axi_timer #(.AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(32)) dut (
    .axi_clk (axi_clk),
    .rst     (rst),
    .AWADDR  (AWADDR),
    .AWVALID (AWVALID),
    .AWREADY (AWREADY),
    .WDDATA  (WDDATA),
    .WDSTRB  (WDSTRB),
    .WDVALID (WDVALID),
    .WDREADY (WDREADY),
    .BRESP   (BRESP),
    .BVALID  (BVALID),
    .BREADY  (BREADY),
    .ARADDR  (ARADDR),
    .ARVALID (ARVALID),
    .ARREADY (ARREADY),
    .RDATA   (RDATA),
    .RRESP   (RRESP),
    .RVALID  (RVALID),
    .RREADY  (RREADY)
  );

  always #5 axi_clk = ~axi_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at 2 ms, required to finish earlier");
    $fatal(1);
  end

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL timeout %s: handshake not seen, required within 16 cycles", name);
  endtask

  // Bus tasks start and return 1 time unit after a rising edge.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    int n;
    AWADDR = addr; WDDATA = data; WDSTRB = strb;
    AWVALID = 1'b1; WDVALID = 1'b1;
    n = 0;
    do begin @(posedge axi_clk); #1; n++; end while (!AWREADY && n < 16);
    if (!AWREADY) timeout("awready");
    @(posedge axi_clk); #1;
    AWVALID = 1'b0;
    obs_aw_pulse = !AWREADY;
    obs_wready   = WDREADY;
    n = 0;
    while (!WDREADY && n < 16) begin @(posedge axi_clk); #1; n++; end
    if (!WDREADY) timeout("wdready");
    @(posedge axi_clk); #1;
    WDVALID = 1'b0;
    obs_wready_drop = !WDREADY;
    n = 0;
    while (!BVALID && n < 16) begin @(posedge axi_clk); #1; n++; end
    if (!BVALID) timeout("bvalid");
    resp = BRESP;
    @(posedge axi_clk); #1;
    obs_b_held = BVALID && (BRESP === resp);
    BREADY = 1'b1;
    @(posedge axi_clk); #1;
    BREADY = 1'b0;
    obs_b_drop = !BVALID;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    int n;
    ARADDR = addr; ARVALID = 1'b1;
    n = 0;
    do begin @(posedge axi_clk); #1; n++; end while (!ARREADY && n < 16);
    if (!ARREADY) timeout("arready");
    @(posedge axi_clk); #1;
    ARVALID = 1'b0;
    n = 0;
    while (!RVALID && n < 16) begin @(posedge axi_clk); #1; n++; end
    if (!RVALID) timeout("rvalid");
    data = RDATA;
    resp = RRESP;
    obs_ar_drop = !ARREADY;
    @(posedge axi_clk); #1;
    obs_r_held = RVALID && (RDATA === data) && (RRESP === resp);
    RREADY = 1'b1;
    @(posedge axi_clk); #1;
    RREADY = 1'b0;
    obs_r_drop = !RVALID;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [1:0]  r;
    logic [40:0] outs;
    rst = 1'b1;
    AWADDR = '0; AWVALID = 1'b0; WDDATA = '0; WDSTRB = '0; WDVALID = 1'b0; BREADY = 1'b0;
    ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b0;
    repeat (3) @(posedge axi_clk);
    #1;
    outs = {AWREADY, WDREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID};
    total++;
    if (outs !== 41'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %h required 0", outs);
    end
    rst = 1'b0;
    @(posedge axi_clk); #1;
    for (int i = 0; i < 3; i++) begin
      axi_read(32'h4 * i, d, r);
      total++;
      if (d !== 32'd0 || r !== 2'b00) begin
        bad++;
        $display("FAIL reset_read_%0h: got data %h resp %b required 0 / 00", 4 * i, d, r);
      end
    end
  endtask

  task automatic test_write_read();
    logic [31:0] d;
    logic [1:0]  r;
    axi_write(32'h4, 32'd10, 4'hF, r);
    total++;
    if (r !== 2'b00) begin bad++; $display("FAIL wr_presc_bresp: got %b required 00", r); end
    total++;
    if ({obs_aw_pulse, obs_wready, obs_wready_drop} !== 3'b111) begin
      bad++;
      $display("FAIL aw_w_timing: got pulse/wready/drop %b required 111",
               {obs_aw_pulse, obs_wready, obs_wready_drop});
    end
    total++;
    if ({obs_b_held, obs_b_drop} !== 2'b11) begin
      bad++;
      $display("FAIL bvalid_hold: got held/drop %b required 11", {obs_b_held, obs_b_drop});
    end
    axi_read(32'h4, d, r);
    total++;
    if (d !== 32'd10 || r !== 2'b00) begin
      bad++;
      $display("FAIL rd_presc: got %h resp %b required 0000000a / 00", d, r);
    end
    total++;
    if ({obs_ar_drop, obs_r_held, obs_r_drop} !== 3'b111) begin
      bad++;
      $display("FAIL r_timing: got ardrop/held/rdrop %b required 111",
               {obs_ar_drop, obs_r_held, obs_r_drop});
    end
  endtask

  // Enable lands on the W-handshake edge; the read samples COUNTER 63 enabled edges later.
  task automatic test_timer_count();
    logic [31:0] d;
    logic [1:0]  r;
    axi_write(32'h4, 32'd10, 4'hF, r);
    axi_write(32'h0, 32'h1, 4'hF, r);
    repeat (60) @(posedge axi_clk);
    #1;
    axi_read(32'h8, d, r);
    total++;
    if (d !== 32'd5) begin bad++; $display("FAIL timer_count: got %0d required 5", d); end
    axi_read(32'h0, d, r);
    total++;
    if (d !== 32'h1) begin bad++; $display("FAIL ctrl_enabled: got %h required 00000001", d); end
  endtask

  task automatic test_clear();
    logic [31:0] d;
    logic [1:0]  r;
    axi_write(32'h0, 32'h2, 4'hF, r);
    axi_read(32'h8, d, r);
    total++;
    if (d !== 32'd0) begin bad++; $display("FAIL clear_count: got %h required 0", d); end
    axi_read(32'h0, d, r);
    total++;
    if (d !== 32'd0) begin bad++; $display("FAIL clear_ctrl: got %h required 0", d); end
    repeat (20) @(posedge axi_clk);
    #1;
    axi_read(32'h8, d, r);
    total++;
    if (d !== 32'd0) begin bad++; $display("FAIL clear_frozen: got %h required 0", d); end
  endtask

  // COUNTER starts at FFFF_FFFE; reads see 3 and then 17 enabled edges.
  task automatic test_wrap();
    logic [31:0] d;
    logic [1:0]  r;
    axi_write(32'h4, 32'd0, 4'hF, r);
    force dut.u_core.count_q = 32'hFFFF_FFFE;
    @(posedge axi_clk); #1;
    release dut.u_core.count_q;
    axi_write(32'h0, 32'h1, 4'hF, r);
    axi_read(32'h8, d, r);
    total++;
    if (d !== 32'd1) begin bad++; $display("FAIL wrap_first: got %h required 00000001", d); end
    repeat (10) @(posedge axi_clk);
    #1;
    axi_read(32'h8, d, r);
    total++;
    if (d !== 32'd15) begin bad++; $display("FAIL wrap_second: got %h required 0000000f", d); end
    axi_write(32'h0, 32'h2, 4'hF, r);
  endtask

  task automatic test_errors_strobe();
    logic [31:0] d;
    logic [1:0]  r;
    axi_write(32'hC, 32'hDEAD, 4'hF, r);
    total++;
    if (r !== 2'b10) begin bad++; $display("FAIL wr_unmapped: got %b required 10", r); end
    axi_read(32'hC, d, r);
    total++;
    if (d !== 32'd0 || r !== 2'b10) begin
      bad++;
      $display("FAIL rd_unmapped: got %h resp %b required 0 / 10", d, r);
    end
    axi_write(32'h4, 32'd10, 4'hF, r);
    axi_write(32'h4, 32'hFFFF_FFFF, 4'b0001, r);
    axi_read(32'h4, d, r);
    total++;
    if (d !== 32'h0000_00FF) begin bad++; $display("FAIL strb_byte0: got %h required 000000ff", d); end
    axi_write(32'h4, 32'h0000_AB00, 4'b0010, r);
    axi_read(32'h1000_0004, d, r);
    total++;
    if (d !== 32'h0000_ABFF || r !== 2'b00) begin
      bad++;
      $display("FAIL strb_byte1_alias: got %h resp %b required 0000abff / 00", d, r);
    end
    axi_write(32'h8, 32'h1234, 4'hF, r);
    total++;
    if (r !== 2'b00) begin bad++; $display("FAIL wr_counter_resp: got %b required 00", r); end
    axi_read(32'h8, d, r);
    total++;
    if (d !== 32'd0) begin bad++; $display("FAIL wr_counter_ignored: got %h required 0", d); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] d;
    logic [1:0]  r;
    AWADDR = 32'h4; WDDATA = 32'h55; WDSTRB = 4'hF;
    AWVALID = 1'b1; WDVALID = 1'b1;
    @(posedge axi_clk); #1;
    rst = 1'b1;
    #1;
    total++;
    if ({AWREADY, WDREADY, BVALID} !== 3'b000) begin
      bad++;
      $display("FAIL abort_outputs: got aw/w/b %b required 000", {AWREADY, WDREADY, BVALID});
    end
    AWVALID = 1'b0; WDVALID = 1'b0;
    @(posedge axi_clk); #1;
    rst = 1'b0;
    @(posedge axi_clk); #1;
    axi_read(32'h4, d, r);
    total++;
    if (d !== 32'd0) begin bad++; $display("FAIL abort_presc: got %h required 0", d); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_timer_count();
    test_clear();
    test_wrap();
    test_errors_strobe();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_timer.md
Name: axi_timer

Overview:
- AXI4-Lite slave wrapping a 32-bit prescaled up-counter.
- Three word registers: CONTROL, PRESCALER, COUNTER.
- Used as a memory-mapped peripheral timer on the system AXI4-Lite interconnect.

Parameters:
AXI_DATA_WIDTH, 32, data bus and register width (only 32 supported)
AXI_ADDR_WIDTH, 32, address bus width

Ports:
axi_clk  in  1  single clock; all logic rising-edge
rst  in  1  reset, asynchronous, active-high
AWADDR  in  32  write address
AWVALID  in  1  write address valid
AWREADY  out  1  write address ready
WDDATA  in  32  write data
WDSTRB  in  4  write byte strobes
WDVALID  in  1  write data valid
WDREADY  out  1  write data ready
BRESP  out  2  write response
BVALID  out  1  write response valid
BREADY  in  1  write response ready
ARADDR  in  32  read address
ARVALID  in  1  read address valid
ARREADY  out  1  read address ready
RDATA  out  32  read data
RRESP  out  2  read response
RVALID  out  1  read data valid
RREADY  in  1  read data ready

Behaviour:
- Reset: all outputs 0. CONTROL, PRESCALER, COUNTER and the internal prescale count are 0.
- Address decode uses AxADDR[3:0] only; upper bits are ignored.
  - 0x0 CONTROL, RW: bit0 ENABLE; bit1 CLEAR is write-1 pulse and reads 0; other bits read 0.
  - 0x4 PRESCALER, RW, 32 bits.
  - 0x8 COUNTER, RO; writes are ignored with OKAY response.
  - Other offsets: reads return 0; both directions respond SLVERR (2'b10). Mapped offsets respond OKAY (2'b00).
- Write FSM (IDLE -> AW -> W -> B):
  - IDLE: when AWVALID && WDVALID, register AWREADY=1 for exactly one cycle and latch AWADDR.
  - After the AW handshake, register WDREADY=1 (held until the W handshake, then dropped).
  - On the W handshake, write the register, applying WDSTRB per byte lane (CONTROL and PRESCALER), and register BVALID=1 with BRESP.
  - Hold BVALID/BRESP until BREADY is seen, then return to IDLE.
  - No new write is accepted while BVALID=1.
- Read FSM (IDLE -> AR -> R):
  - When ARVALID && !RVALID, register ARREADY=1 and hold it until the handshake.
  - On the handshake, capture the register value into RDATA and RRESP the same cycle as RVALID rises, i.e. RVALID and RDATA update together.
  - Hold RDATA/RRESP stable while RVALID=1; clear RVALID on RVALID && RREADY.
- Read and write channels are independent. A simultaneous read and write to the same register returns the pre-write value.
- Timer core:
  - While ENABLE=1, the prescale count increments each cycle.
  - When the prescale count equals PRESCALER: the prescale count goes to 0 and COUNTER increments. This gives a period of PRESCALER+1 cycles; PRESCALER=0 increments every cycle.
  - COUNTER wraps 0xFFFF_FFFF -> 0.
  - ENABLE=0 freezes both counts.
  - A CONTROL write with bit1=1 clears COUNTER and the prescale count in the write cycle; clear takes priority over increment.
  - ENABLE takes the written bit0 in the same write.
  - Writing PRESCALER mid-count takes effect at the next compare. If the prescale count is already above the new value, the prescale count runs up to wrap before matching; this is accepted.
- Reset asserted mid-transaction aborts it immediately; all state returns to reset values.

Decomposition:
- Package axi_timer_pkg holds:
  - address offsets ADDR_CONTROL=0x0, ADDR_PRESCALER=0x4, ADDR_COUNTER=0x8;
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10;
  - CTRL_EN_BIT=0, CTRL_CLR_BIT=1;
  - write/read FSM state enums.
- One sub-module, timer_core:
  - inputs: clock, reset, enable, clear pulse, prescaler;
  - output: counter value.
- The top holds the AXI FSMs and the register file.

Test Plan:
- Reset then read 0x0, 0x4, 0x8 -> RDATA 0 each, RRESP OKAY.
- Write 10 to 0x4, read 0x4 -> 10, BRESP OKAY. Verify AWREADY is a one-cycle pulse, WDREADY follows, BVALID holds until BREADY.
- PRESCALER=10, write 0x1 to 0x0, wait 60 cycles, read 0x8 -> 5 or 6. A bench with exact cycle counting expects floor(elapsed enabled cycles / 11).
- Write 0x2 to 0x0, read 0x8 -> 0. Read 0x0 -> 0 (enable off, CLEAR self-cleared). Wait 20 cycles and read 0x8 -> still 0.
- PRESCALER=0, enable, force COUNTER near 0xFFFF_FFFF (hierarchical deposit) -> wraps to 0 and keeps counting.
- Write 0xDEAD to 0xC -> BRESP SLVERR. Read 0xC -> RDATA 0, RRESP SLVERR. WDSTRB=4'b0001 write of 0xFFFF_FFFF to 0x4 over 10 -> PRESCALER 0xFF.
